// File: rtl/sobel_edge_detect_3x3_pkg.sv
// Shared constants and types for the 3x3-window image filters.
// Pipeline depth, output saturation limit and the edge-counter state encoding.
package sobel_edge_detect_3x3_pkg;

  localparam int unsigned PIPE_DEPTH = 4;
  localparam int unsigned SAT_LIMIT  = 255;

  typedef enum logic [1:0] {
    StArm,
    StIdle,
    StFrame
  } cnt_state_e;

endpackage

// File: rtl/sobel_edge_counter.sv
// Per-frame edge counter: vsync edge detect, saturating pixel counter and the
// edge_count latch with its one-cycle update strobe.
module sobel_edge_counter
  import sobel_edge_detect_3x3_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync,
  input  logic                 href,
  input  logic                 edge_bit,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 edge_count_valid
);

  cnt_state_e           state_q, state_d;
  logic                 vsync_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] edge_count_q, edge_count_d;
  logic                 valid_q, valid_d;
  logic                 rise, fall, hit;

  // StArm waits for vsync low after reset so a frame already in flight is never reported.
  always_comb begin
    rise         = vsync & ~vsync_q;
    fall         = ~vsync & vsync_q;
    hit          = href & edge_bit;
    state_d      = state_q;
    cnt_d        = cnt_q;
    edge_count_d = edge_count_q;
    valid_d      = 1'b0;
    if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    unique case (state_q)
      StArm: begin
        if (!vsync) state_d = StIdle;
      end
      StIdle: begin
        if (rise) begin
          state_d = StFrame;
          cnt_d   = CNT_WIDTH'(hit);
        end
      end
      StFrame: begin
        if (fall) begin
          state_d      = StIdle;
          edge_count_d = cnt_q;
          valid_d      = 1'b1;
        end
      end
      default: state_d = StArm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StArm;
      vsync_q      <= 1'b0;
      cnt_q        <= '0;
      edge_count_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      cnt_q        <= cnt_d;
      edge_count_q <= edge_count_d;
      valid_q      <= valid_d;
    end
  end

  assign edge_count       = edge_count_q;
  assign edge_count_valid = valid_q;

endmodule

// File: rtl/sobel_edge_detect_3x3.sv
// Four-stage Sobel gradient pipeline on a 3x3 window with saturated magnitude,
// per-frame thresholded edge flag and a per-frame edge pixel count.
module sobel_edge_detect_3x3
  import sobel_edge_detect_3x3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  matrix_frame_vsync,
  input  logic                  matrix_frame_href,
  input  logic [DATA_WIDTH-1:0] matrix_p11,
  input  logic [DATA_WIDTH-1:0] matrix_p12,
  input  logic [DATA_WIDTH-1:0] matrix_p13,
  input  logic [DATA_WIDTH-1:0] matrix_p21,
  input  logic [DATA_WIDTH-1:0] matrix_p22,
  input  logic [DATA_WIDTH-1:0] matrix_p23,
  input  logic [DATA_WIDTH-1:0] matrix_p31,
  input  logic [DATA_WIDTH-1:0] matrix_p32,
  input  logic [DATA_WIDTH-1:0] matrix_p33,
  input  logic [7:0]            threshold,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic [7:0]            post_img_Data,
  output logic                  post_img_Bit,
  output logic [CNT_WIDTH-1:0]  edge_count,
  output logic                  edge_count_valid
);

  localparam int unsigned PS_W  = DATA_WIDTH + 2;
  localparam int unsigned SUM_W = DATA_WIDTH + 3;
  localparam logic [SUM_W-1:0] SAT_SUM = SUM_W'(SAT_LIMIT);

  logic                  vsync_in_q;
  logic [7:0]            frame_threshold_q;
  logic [PIPE_DEPTH-1:0] vsync_pipe_q, href_pipe_q;
  logic [PS_W-1:0]       gx_p_q, gx_n_q, gy_p_q, gy_n_q;
  logic [PS_W-1:0]       gx_abs_q, gy_abs_q;
  logic [SUM_W-1:0]      sum_q;
  logic [7:0]            data_q, data_d;
  logic                  bit_q, bit_d;

  // The centre pixel carries zero weight in both Sobel kernels.
  logic unused_p22;
  assign unused_p22 = ^matrix_p22;

  // Threshold is captured once at frame start so mid-frame changes cannot split a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_in_q        <= 1'b0;
      frame_threshold_q <= '0;
    end else begin
      vsync_in_q <= matrix_frame_vsync;
      if (matrix_frame_vsync && !vsync_in_q) begin
        frame_threshold_q <= threshold;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_pipe_q <= '0;
      href_pipe_q  <= '0;
    end else begin
      vsync_pipe_q <= {vsync_pipe_q[PIPE_DEPTH-2:0], matrix_frame_vsync};
      href_pipe_q  <= {href_pipe_q[PIPE_DEPTH-2:0], matrix_frame_href};
    end
  end

  // Stage 4 output is forced to zero whenever the window alongside it is not valid.
  always_comb begin
    data_d = '0;
    bit_d  = 1'b0;
    if (href_pipe_q[PIPE_DEPTH-2]) begin
      data_d = (sum_q > SAT_SUM) ? 8'(SAT_LIMIT) : sum_q[7:0];
      bit_d  = (sum_q > SUM_W'(frame_threshold_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p_q   <= '0;
      gx_n_q   <= '0;
      gy_p_q   <= '0;
      gy_n_q   <= '0;
      gx_abs_q <= '0;
      gy_abs_q <= '0;
      sum_q    <= '0;
      data_q   <= '0;
      bit_q    <= 1'b0;
    end else begin
      gx_p_q   <= {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
      gx_n_q   <= {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
      gy_p_q   <= {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};
      gy_n_q   <= {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
      gx_abs_q <= (gx_p_q >= gx_n_q) ? (gx_p_q - gx_n_q) : (gx_n_q - gx_p_q);
      gy_abs_q <= (gy_p_q >= gy_n_q) ? (gy_p_q - gy_n_q) : (gy_n_q - gy_p_q);
      sum_q    <= {1'b0, gx_abs_q} + {1'b0, gy_abs_q};
      data_q   <= data_d;
      bit_q    <= bit_d;
    end
  end

  assign post_frame_vsync = vsync_pipe_q[PIPE_DEPTH-1];
  assign post_frame_href  = href_pipe_q[PIPE_DEPTH-1];
  assign post_img_Data    = data_q;
  assign post_img_Bit     = bit_q;

  sobel_edge_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_edge_counter (
    .clk             (clk),
    .rst_n           (rst_n),
    .vsync           (post_frame_vsync),
    .href            (post_frame_href),
    .edge_bit        (post_img_Bit),
    .edge_count      (edge_count),
    .edge_count_valid(edge_count_valid)
  );

endmodule

// File: tb/tb_sobel_edge_detect_3x3.sv
// Directed bench: fixed 3x3 windows with hand-computed results, then 16x5 frames
// from a behavioural frame source and window generator with edge replication.
module tb_sobel_edge_detect_3x3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, href;
  logic [7:0]  p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [7:0]  threshold;
  logic        post_frame_vsync, post_frame_href, post_img_Bit, edge_count_valid;
  logic [7:0]  post_img_Data;
  logic [19:0] edge_count;

  int tests_run = 0;
  int fail_cnt  = 0;
  int strobes = 0, last_count = -1, nz_data = 0, bit_ones = 0, gate_err = 0;
  int data128 = 0, data64 = 0;

  always #5 clk = ~clk;

  sobel_edge_detect_3x3 #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (20)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .matrix_frame_vsync(vsync),
    .matrix_frame_href (href),
    .matrix_p11        (p11),
    .matrix_p12        (p12),
    .matrix_p13        (p13),
    .matrix_p21        (p21),
    .matrix_p22        (p22),
    .matrix_p23        (p23),
    .matrix_p31        (p31),
    .matrix_p32        (p32),
    .matrix_p33        (p33),
    .threshold         (threshold),
    .post_frame_vsync  (post_frame_vsync),
    .post_frame_href   (post_frame_href),
    .post_img_Data     (post_img_Data),
    .post_img_Bit      (post_img_Bit),
    .edge_count        (edge_count),
    .edge_count_valid  (edge_count_valid)
  );

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (edge_count_valid) begin
      strobes++;
      last_count = int'(edge_count);
    end
    if (post_img_Data != 8'd0) nz_data++;
    if (post_img_Bit) bit_ones++;
    if (post_img_Data == 8'd128) data128++;
    if (post_img_Data == 8'd64) data64++;
    if (!post_frame_href && (post_img_Data != 8'd0 || post_img_Bit)) gate_err++;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input logic [71:0] w);
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = w;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vsync"}, int'(post_frame_vsync), 0);
    check({tag, "_href"}, int'(post_frame_href), 0);
    check({tag, "_data"}, int'(post_img_Data), 0);
    check({tag, "_bit"}, int'(post_img_Bit), 0);
    check({tag, "_count"}, int'(edge_count), 0);
    check({tag, "_valid"}, int'(edge_count_valid), 0);
  endtask

  // One window in its own frame; result must appear exactly 4 cycles later.
  task automatic win_test(input string tag, input logic [71:0] w, input logic [7:0] thr,
                          input int exp_d, input int exp_b);
    vsync = 1'b0; href = 1'b0; set_win('0);
    step(); step();
    vsync = 1'b1; href = 1'b1; threshold = thr; set_win(w);
    step();
    href = 1'b0; set_win('0); threshold = ~thr;
    step(); step();
    check({tag, "_lat3_data"}, int'(post_img_Data), 0);
    step();
    check({tag, "_data"}, int'(post_img_Data), exp_d);
    check({tag, "_bit"}, int'(post_img_Bit), exp_b);
    check({tag, "_href"}, int'(post_frame_href), 1);
    step();
    check({tag, "_after"}, int'(post_img_Data), 0);
    vsync = 1'b0;
  endtask

  function automatic logic [7:0] pix(input int kind, input int x, input int y);
    int cx, cy;
    cx = (x < 0) ? 0 : ((x > 15) ? 15 : x);
    cy = (y < 0) ? 0 : ((y > 4) ? 4 : y);
    return (kind == 0) ? 8'h40 : 8'(cx * 16 + cy * 0);
  endfunction

  task automatic drive_pixels(input int kind, input int npix, input bit change_mid);
    for (int i = 0; i < npix; i++) begin
      int x, y;
      x = i % 16;
      y = i / 16;
      if (change_mid && i == 40) threshold = 8'd255;
      href = 1'b1;
      p11 = pix(kind, x - 1, y - 1); p12 = pix(kind, x, y - 1); p13 = pix(kind, x + 1, y - 1);
      p21 = pix(kind, x - 1, y);     p22 = pix(kind, x, y);     p23 = pix(kind, x + 1, y);
      p31 = pix(kind, x - 1, y + 1); p32 = pix(kind, x, y + 1); p33 = pix(kind, x + 1, y + 1);
      step();
      if (x == 15) begin
        href = 1'b0; set_win('0);
        step(); step();
      end
    end
    href = 1'b0;
    set_win('0);
  endtask

  task automatic frame_start(input logic [7:0] thr);
    vsync = 1'b0; href = 1'b0; set_win('0);
    repeat (3) step();
    vsync = 1'b1; threshold = thr;
    step(); step();
  endtask

  task automatic run_frame(input string tag, input int kind, input logic [7:0] thr,
                           input bit change_mid, input int exp_count, input int exp_bits,
                           output int nz_d, output int d128_d, output int d64_d);
    int s0, b0, n0, g0, h0, l0;
    s0 = strobes; b0 = bit_ones; n0 = nz_data; g0 = gate_err; h0 = data128; l0 = data64;
    frame_start(thr);
    drive_pixels(kind, 80, change_mid);
    repeat (6) step();
    vsync = 1'b0;
    repeat (8) step();
    check({tag, "_strobes"}, strobes - s0, 1);
    check({tag, "_count"}, last_count, exp_count);
    check({tag, "_bits"}, bit_ones - b0, exp_bits);
    check({tag, "_gating"}, gate_err - g0, 0);
    nz_d = nz_data - n0; d128_d = data128 - h0; d64_d = data64 - l0;
  endtask

  initial begin
    int nz, d128, d64, s0;
    rst_n = 1'b0; vsync = 1'b1; href = 1'b1; threshold = 8'd5;
    set_win({8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255});
    repeat (3) step();
    check_all_zero("reset");
    vsync = 1'b0; href = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    win_test("lr_edge", {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255},
             8'd100, 255, 1);
    win_test("p13_thr20", {8'd0, 8'd0, 8'd10, 48'd0}, 8'd20, 20, 0);
    win_test("p13_thr19", {8'd0, 8'd0, 8'd10, 48'd0}, 8'd19, 20, 1);
    win_test("top_row", {8'd50, 8'd50, 8'd50, 48'd0}, 8'd199, 200, 1);
    win_test("p32_only", {56'd0, 8'd100, 8'd0}, 8'd0, 200, 1);
    win_test("p21_only", {24'd0, 8'd60, 40'd0}, 8'd119, 120, 1);
    win_test("sum254", {40'd0, 8'd127, 24'd0}, 8'd255, 254, 0);
    win_test("sum256", {40'd0, 8'd128, 24'd0}, 8'd255, 255, 1);
    repeat (8) step();

    run_frame("uniform", 0, 8'd0, 1'b0, 0, 0, nz, d128, d64);
    check("uniform_nonzero_data", nz, 0);

    run_frame("ramp", 1, 8'd50, 1'b1, 80, 80, nz, d128, d64);
    check("ramp_data128", d128, 70);
    check("ramp_data64", d64, 10);

    // Reset in the middle of a frame: outputs clear at once and no strobe follows.
    s0 = strobes;
    frame_start(8'd50);
    drive_pixels(1, 40, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    vsync = 1'b0;
    repeat (3) step();
    check("midrst_hold_count", int'(edge_count), 0);
    rst_n = 1'b1;
    repeat (10) step();
    check("midrst_no_strobe", strobes - s0, 0);

    run_frame("post_rst", 1, 8'd50, 1'b0, 80, 80, nz, d128, d64);

    // vsync pulse with no valid windows reports zero edges.
    s0 = strobes;
    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    repeat (10) step();
    check("empty_strobes", strobes - s0, 1);
    check("empty_count", last_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
